// File: rtl/shared_mem_pkg.sv
// -----------------------------------------------------------------------------
// shared_mem_pkg
// Shared definitions for the shared-memory arbiter slice:
//   - arb_state_t : transaction FSM states (IDLE / ACCESS / RESP)
//   - MAX_PORTS   : upper bound on requester channels
//   - WAIT_CNT_W  : width of the access wait-state counter (0..15 extra cycles)
// -----------------------------------------------------------------------------
package shared_mem_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/shared_mem_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at the port after
// last_grant and wraps, so the most recently served port has lowest priority.
// Ports:
//   req        in  N      request vector
//   last_grant in  IDX_W  index of the previously granted port
//   grant      out N      one-hot grant (all zero when nothing requests)
//   grant_idx  out IDX_W  binary index of the granted port
//   grant_any  out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import shared_mem_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] cand_idx_s;

  // Walk the ports in rotated order and take the first requester.
  always_comb begin
    grant      = '0;
    grant_idx  = last_grant;
    grant_any  = 1'b0;
    cand_idx_s = last_grant;
    for (int i = 1; i <= N; i++) begin
      cand_idx_s = IDX_W'((int'(last_grant) + i) % N);
      if (!grant_any && req[cand_idx_s]) begin
        grant_any         = 1'b1;
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arb.sv
// -----------------------------------------------------------------------------
// shared_mem_arb
// Single-ported word memory shared by NUM_PORTS requesters (port 0 = fetch,
// others = data). One transaction in flight: IDLE grants a port round-robin,
// ACCESS waits WAIT_STATES+1 cycles and performs the read or byte-masked write
// on its last cycle, RESP pulses rsp_valid for the granted port.
//
// Optional feature macro: SHARED_MEM_ARB_ERR_EN
//   defined   : out-of-range address -> rsp_err=1, rsp_rdata=0, write dropped
//   undefined : word index wraps modulo DEPTH, rsp_err tied low
//
// Ports:
//   clk        in   1                  clock, rising edge
//   reset      in   1                  asynchronous active-low reset
//   req_valid  in   NUM_PORTS          per-port request valid
//   req_ready  out  NUM_PORTS          per-port accept (combinational, IDLE only)
//   req_we     in   NUM_PORTS          1 = write, 0 = read
//   req_addr   in   NUM_PORTS*32       per-port byte address
//   req_wdata  in   NUM_PORTS*DATA_W   per-port write data
//   req_be     in   NUM_PORTS*DATA_W/8 per-port byte enables
//   rsp_valid  out  NUM_PORTS          one-cycle response pulse
//   rsp_rdata  out  DATA_W             read data (0 for writes)
//   rsp_err    out  1                  address error flag
// DEPTH is expected to be a power of two >= 2.
// -----------------------------------------------------------------------------
module shared_mem_arb
  import shared_mem_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*32-1:0]       req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_be,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);

  arb_state_t             state_r;
  arb_state_t             next_state_s;
  logic                   armed_r;
  logic [IDX_W-1:0]       last_grant_r;
  logic [IDX_W-1:0]       grant_idx_r;
  logic [IDX_W-1:0]       arb_idx_s;
  logic [NUM_PORTS-1:0]   arb_grant_s;
  logic                   arb_any_s;
  logic [NUM_PORTS-1:0]   req_ready_s;
  logic                   accept_s;
  logic                   final_s;
  logic                   commit_wr_s;
  logic                   we_r;
  logic [31:0]            addr_r;
  logic [DATA_W-1:0]      wdata_r;
  logic [BYTES-1:0]       be_r;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r;
  logic [NUM_PORTS-1:0]   rsp_valid_r;
  logic [DATA_W-1:0]      rsp_rdata_r;
  logic                   rsp_err_r;
  logic [31:0]            offset_s;
  logic [AW-1:0]          mem_idx_s;
  logic                   addr_err_s;
  logic [DATA_W-1:0]      mem_r [DEPTH];

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s),
    .grant_any  (arb_any_s)
  );

  // armed_r keeps req_ready low while reset is asserted (IDLE alone would
  // otherwise expose the combinational grant during reset).
  assign accept_s    = (state_r == ST_IDLE) && armed_r && arb_any_s;
  assign final_s     = (state_r == ST_ACCESS) && (wait_cnt_r == WAIT_LAST);
  assign commit_wr_s = final_s && we_r && !addr_err_s;

  // Address decode of the latched request.
  always_comb begin
    offset_s  = addr_r - BASE_ADDR;
    mem_idx_s = AW'(offset_s >> OFF_W);
`ifdef SHARED_MEM_ARB_ERR_EN
    addr_err_s = (addr_r < BASE_ADDR) || ((offset_s >> OFF_W) >= 32'(DEPTH));
`else
    addr_err_s = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state and combinational req_ready.
  always_comb begin
    next_state_s = state_r;
    req_ready_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_ACCESS;
          req_ready_s  = arb_grant_s;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (final_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  assign req_ready = req_ready_s;

  // Request latch, wait counter, grant history and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_r      <= 1'b0;
      last_grant_r <= IDX_W'(NUM_PORTS - 1);
      grant_idx_r  <= '0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0;
      wdata_r      <= '0;
      be_r         <= '0;
      wait_cnt_r   <= '0;
      rsp_valid_r  <= '0;
      rsp_rdata_r  <= '0;
      rsp_err_r    <= 1'b0;
    end else begin
      armed_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= '0;
          wait_cnt_r  <= '0;
          if (accept_s) begin
            last_grant_r <= arb_idx_s;
            grant_idx_r  <= arb_idx_s;
            we_r         <= req_we[arb_idx_s];
            addr_r       <= req_addr[int'(arb_idx_s)*32 +: 32];
            wdata_r      <= req_wdata[int'(arb_idx_s)*DATA_W +: DATA_W];
            be_r         <= req_be[int'(arb_idx_s)*BYTES +: BYTES];
          end
        end
        ST_ACCESS: begin
          if (final_s) begin
            wait_cnt_r               <= '0;
            rsp_valid_r[grant_idx_r] <= 1'b1;
            rsp_err_r                <= addr_err_s;
            // Nonblocking read: returns the word as it was before any write
            // committed on this same edge.
            rsp_rdata_r <= (we_r || addr_err_s) ? '0 : mem_r[mem_idx_s];
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_CNT_W'(1);
          end
        end
        ST_RESP: rsp_valid_r <= '0;
        default: rsp_valid_r <= '0;
      endcase
    end
  end

  // Memory array: contents survive reset; an aborted ACCESS never reaches
  // final_s because reset forces the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (commit_wr_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_r[b]) begin
          mem_r[mem_idx_s][b*8 +: 8] <= wdata_r[b*8 +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_shared_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arb
// Bench for shared_mem_arb: a 2-port WAIT_STATES=1 instance driven from a
// vector table and hand-written sequences with a response scoreboard, plus a
// 1-port WAIT_STATES=0 instance for the zero-wait latency corner.
// Honours SHARED_MEM_ARB_ERR_EN for out-of-range expectations.
// -----------------------------------------------------------------------------
module tb_shared_mem_arb;

  localparam int WS = 1;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_be;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        b_valid, b_ready, b_we, b_rsp_valid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[13];

  shared_mem_arb #(
    .NUM_PORTS(2), .DATA_W(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(WS)
  ) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  shared_mem_arb #(
    .NUM_PORTS(1), .DATA_W(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) u_dut_ws0 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
  endtask

  // Monitor: acceptance bookkeeping and scoreboard compare, sampled at negedge.
  initial forever begin
    @(negedge clk);
    if (reset && ((req_valid & req_ready) != 2'b00)) begin
      accept_cyc = cyc;
      chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
    end
    if (rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_port", 32'(rsp_valid), 32'd1 << e.port);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - accept_cyc), 32'(WS + 2));
      end
    end
  end

  task automatic drive(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    req_we[p]             = we;
    req_addr[p*32 +: 32]  = addr;
    req_wdata[p*32 +: 32] = wd;
    req_be[p*4 +: 4]      = be;
    req_valid[p]          = 1'b1;
  endtask

  task automatic wait_ready(input int p, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("ready_timeout");
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      fail_timeout("rsp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic txn(input int p, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] exp_rd, input logic exp_err);
    bit   ok;
    exp_t e;
    @(posedge clk);
    #1;
    e.port  = p;
    e.rdata = exp_rd;
    e.err   = exp_err;
    exp_q.push_back(e);
    drive(p, we, addr, wd, be);
    wait_ready(p, ok);
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    wait_drain();
  endtask

  task automatic b_wait(input int which, output int at);
    bit ok;
    ok = 1'b0;
    at = -100;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if ((which == 0 && b_ready) || (which == 1 && b_rsp_valid)) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) fail_timeout(which == 0 ? "ws0_ready_timeout" : "ws0_rsp_timeout");
  endtask

  initial begin
    bit   ok;
    int   n_sent[2];
    int   p;
    int   n_rsp;
    int   a0, a1, r0, r1;
    exp_t e;

    vecs[0]  = '{1, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1, 1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1'b1, 32'h20,   32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1, 1'b1, 32'h20,   32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{0, 1'b0, 32'h20,   32'h0,        4'hF, 32'hAA22CC44, 1'b0};
    vecs[5]  = '{1, 1'b0, 32'h23,   32'h0,        4'hF, 32'hAA22CC44, 1'b0};
    vecs[6]  = '{0, 1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1, 1'b0, 32'h1000, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1, 1'b0, 32'h0,    32'h0,        4'hF, 32'h12345678, 1'b0};
    vecs[10] = '{0, 1'b1, 32'h30,   32'h55667788, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1, 1'b1, 32'hFFC,  32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{0, 1'b0, 32'hFFC,  32'h0,        4'hF, 32'h0BADCAFE, 1'b0};
`ifdef SHARED_MEM_ARB_ERR_EN
    vecs[7]  = '{1, 1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[8]  = '{0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1, 1'b0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
`endif

    reset     = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = 64'h0;
    req_wdata = 64'h0;
    req_be    = 8'h0;
    b_valid   = 1'b0;
    b_we      = 1'b0;
    b_addr    = 32'h0;
    b_wdata   = 32'h0;
    b_be      = 4'h0;

    // Both ports request during reset; outputs must stay quiet.
    drive(0, 1'b1, 32'h100, 32'h0000A000, 4'hF);
    drive(1, 1'b1, 32'h200, 32'h0000B000, 4'hF);
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      e.port  = k % 2;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Continuous requests from both ports: grants alternate 0,1,0,1,...
    n_sent[0] = 1;
    n_sent[1] = 1;
    for (int k = 0; k < 8; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        fail_timeout("rr_grant_timeout");
        break;
      end
      p = req_ready[1] ? 1 : 0;
      chk("rr_order", 32'(p), 32'(k % 2));
      @(posedge clk);
      #1;
      if (n_sent[p] < 4) begin
        drive(p, 1'b1, 32'h100 * (p + 1) + 32'(n_sent[p] * 4), 32'h0000A000 + 32'(k), 4'hF);
        n_sent[p]++;
      end else begin
        req_valid[p] = 1'b0;
      end
    end
    req_valid = 2'b00;
    wait_drain();

    // Table-driven single transactions.
    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Reset pulse during ACCESS of a write to 0x30: aborted, no response.
    @(posedge clk);
    #1;
    drive(1, 1'b1, 32'h30, 32'h99999999, 4'hF);
    wait_ready(1, ok);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    chk("abort_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_reset_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    n_rsp = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) n_rsp++;
    end
    chk("abort_no_rsp", 32'(n_rsp), 32'd0);
    txn(1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h55667788, 1'b0);

    // Zero wait states, single port: write then back-to-back read.
    @(posedge clk);
    #1;
    b_we    = 1'b1;
    b_addr  = 32'h8;
    b_wdata = 32'h13579BDF;
    b_be    = 4'hF;
    b_valid = 1'b1;
    b_wait(0, a0);
    @(posedge clk);
    #1;
    b_we = 1'b0;
    b_wait(1, r0);
    chk("ws0_wr_latency", 32'(r0 - a0), 32'd2);
    chk("ws0_wr_rdata", b_rdata, 32'h0);
    b_wait(0, a1);
    chk("ws0_next_ready", 32'(a1 - a0), 32'd3);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_wait(1, r1);
    chk("ws0_rd_latency", 32'(r1 - a1), 32'd2);
    chk("ws0_rd_rdata", b_rdata, 32'h13579BDF);
    chk("ws0_rd_err", 32'(b_err), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_mem_arb.md
SHARED_MEM_ARB -- requirements
Module: shared_mem_arb

Interface
REQ-001 Parameter NUM_PORTS, default 2, shall set the number of requester channels (1..8); port 0 is fetch, the rest are data.
REQ-002 Parameter DATA_W, default 32, shall set the word width (multiple of 8).
REQ-003 Parameter DEPTH, default 1024, shall set the memory depth in words (power of two).
REQ-004 Parameter BASE_ADDR, default 32'h0, shall set the byte address of word 0.
REQ-005 Parameter WAIT_STATES, default 1, shall set the extra access cycles (0..15).
REQ-006 clk  in  1  sole clock; all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  NUM_PORTS  per-port request valid.
REQ-009 req_ready  out  NUM_PORTS  per-port request accepted this cycle.
REQ-010 req_we  in  NUM_PORTS  per-port write (1) / read (0).
REQ-011 req_addr  in  NUM_PORTS x 32  per-port byte address.
REQ-012 req_wdata  in  NUM_PORTS x DATA_W  per-port write data.
REQ-013 req_be  in  NUM_PORTS x DATA_W/8  per-port byte enables.
REQ-014 rsp_valid  out  NUM_PORTS  one-cycle per-port response pulse.
REQ-015 rsp_rdata  out  DATA_W  shared read data, valid with any rsp_valid.
REQ-016 rsp_err  out  1  error flag, valid with any rsp_valid.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-018 IDLE: if any req_valid, grant one port by round-robin from last_grant+1; assert req_ready for that port only, combinationally, in the same cycle; latch we/addr/wdata/be; go to ACCESS.
REQ-019 ACCESS: hold for WAIT_STATES+1 cycles (counter); on the final cycle perform the read, or write only the enabled bytes; go to RESP.
REQ-020 RESP: assert rsp_valid for the granted port for exactly one cycle with rsp_rdata/rsp_err; return to IDLE.
REQ-021 Latency: acceptance edge N -> rsp_valid high in cycle N+WAIT_STATES+2; a new grant is no earlier than the cycle after RESP.
REQ-022 Word index = (addr - BASE_ADDR) >> log2(DATA_W/8); low address bits are ignored.
REQ-023 A write response returns rsp_rdata = 0; a read returns pre-existing data, never data from a same-transaction write.
REQ-024 The requester holds req_* stable until req_ready; unaccepted ports keep waiting without loss.
REQ-025 last_grant updates only on grant; with a single requester, back-to-back grants to the same port are permitted.
REQ-026 When req_valid is 0 outside a grant, the arbiter shall have no side effects.

Reset
REQ-027 Reset asserted shall force IDLE, last_grant = NUM_PORTS-1 (first grant to port 0), req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and wait counter = 0.
REQ-028 Reset during ACCESS shall abort the transaction; no memory write is committed and no response is issued.
REQ-029 Memory contents are not cleared by reset.

Configuration
REQ-030 With macro SHARED_MEM_ARB_ERR_EN defined, an index >= DEPTH or addr < BASE_ADDR shall give rsp_err = 1 and rsp_rdata = 0, and a write shall be suppressed.
REQ-031 Without SHARED_MEM_ARB_ERR_EN, the index shall wrap modulo DEPTH, and rsp_err shall be tied to 0.

Structure
REQ-032 Package shared_mem_pkg shall hold the FSM state enum, the MAX_PORTS constant, and the wait-counter width constant.
REQ-033 Sub-module rr_arbiter (request vector + last_grant -> one-hot grant) shall be a separate module; the memory array stays in shared_mem_arb.

Verification
REQ-034 Port 1 write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 with WAIT_STATES=1 -> read rsp_valid 3 cycles after acceptance, rsp_rdata = 0xDEADBEEF.
REQ-035 Ports 0 and 1 request continuously from reset -> grants alternate 0,1,0,1; each port receives exactly one rsp_valid per grant.
REQ-036 Write 0xAABBCCDD to 0x20, then write 0x11223344 with be=4'b0101 -> readback 0xAA22CC44.
REQ-037 reset low for one cycle during ACCESS of a write to 0x30 -> no rsp_valid; a later read of 0x30 returns the old value.
REQ-038 DEPTH=1024, read 0x1000: with SHARED_MEM_ARB_ERR_EN -> rsp_err=1, rsp_rdata=0; without it -> data of word 0, rsp_err=0.
REQ-039 WAIT_STATES=0, single port read -> rsp_valid 2 cycles after acceptance; next req_ready no earlier than 3 cycles after acceptance.
